sdram_dl_writer: RTL and testbench
==================================

Name: sdram_dl_writer

Overview:
- Initiator side of the SDRAM controller's toggle-handshake write port (req/ack/we/a/ds/d).
- Converts the byte-wide ioctl ROM download stream from the MiST user_io/data_io block into 16-bit SDRAM word writes.
- Buffers words in a small FIFO and pairs bytes into full words where possible.
- Throttles the download source and reports when every buffered write has been acknowledged.

Parameters:
- FIFO_DEPTH, 4, number of word entries buffered; power of two, 2..16.
- BASE_WORD, 23'h0, word offset added to the download word address before it is driven on port_a.

Ports:
- clk, in, 1, system/SDRAM clock; same clock as the controller.
- init_n, in, 1, asynchronous active-low reset.
- ioctl_downl, in, 1, download active.
- ioctl_wr, in, 1, one-cycle strobe: byte valid.
- ioctl_addr, in, 25, byte address of ioctl_dout.
- ioctl_dout, in, 8, download byte.
- dl_wait, out, 1, high asks the source to stop strobing.
- dl_done, out, 1, one-cycle pulse when the download has ended and all writes are acked.
- overflow, out, 1, sticky: a byte was dropped because the FIFO was full.
- port_req, out, 1, request toggle to the controller.
- port_ack, in, 1, acknowledge toggle from the controller.
- port_we, out, 1, write enable; constant 1 while a request is pending.
- port_a, out, 23, SDRAM word address [23:1].
- port_ds, out, 2, byte strobes: [1] high byte, [0] low byte.
- port_d, out, 16, write data.

Behaviour:
- Reset (init_n low, asynchronous), all values 0:
  - port_req, port_we, port_a, port_ds, port_d.
  - dl_wait, dl_done, overflow.
  - FIFO pointers and count; half-word holding register empty.
  - FSM in IDLE.
  - The controller's port state must be reset together with this block, so both toggles start equal.
- Byte lane mapping: even byte (ioctl_addr[0]=0) goes to d[7:0] / ds[0]; odd byte goes to d[15:8] / ds[1].
- Word address = ioctl_addr[23:1] + BASE_WORD, modulo 2^23 (wraps silently). ioctl_addr[24] is ignored.
- Assembler: one holding register containing {addr, low byte, valid}. At most one FIFO push per cycle.
  - Even byte, holder empty: load holder. No push.
  - Even byte, holder valid: push holder as ds=01, then load the new byte into the holder.
  - Odd byte, holder valid, same word address: push {odd, held} with ds=11; clear holder.
  - Odd byte, holder empty or different address: push {odd, 8'h00} with ds=10. Holder unchanged; if valid, it stays pending.
- Flush: on the ioctl_downl 1->0 edge, a valid holder is pushed as ds=01 on the next cycle.
- FIFO:
  - Synchronous, FIFO_DEPTH entries, each {a[22:0], ds[1:0], d[15:0]}.
  - Push when full: the byte is dropped, overflow sets and stays set until reset.
  - A push and a pop in the same cycle are both permitted.
- Throttle: dl_wait = (count >= FIFO_DEPTH-1), registered, asserted one cycle after the condition. This leaves one slot of slack for a strobe already in flight.
- FSM (pending := port_req != port_ack):
  - IDLE: if FIFO is not empty, pop the head into port_a/ds/d, set port_we=1, toggle port_req; go to WAIT.
  - WAIT: hold port_a/ds/d/we stable. When port_ack == port_req, set port_we=0 and go to IDLE.
  - A new request is never issued in the same cycle the ack is seen. The minimum spacing is therefore 1 idle cycle between toggles.
  - An ack toggle arriving while not pending is ignored.
- Done: dl_done pulses for 1 cycle on the first cycle where all of the following hold:
  - ioctl_downl=0;
  - the flush has completed;
  - FIFO is empty;
  - FSM is in IDLE;
  - a download was in progress since the last done pulse.
  A falling ioctl_downl with nothing written still produces the pulse.
- Reset mid-transfer: the outstanding request is abandoned and FIFO contents are lost. No partial word is written by this block afterwards.
- A rising ioctl_downl while writes from the previous download are still pending is legal; the queue drains in order.

Test Plan:
- Sequential bytes 00..07 at addr 0..7, BASE_WORD=0, ack returned 3 cycles after each toggle -> 4 writes: a=0..3, ds=11, d=16'h0100, 0302, 0504, 0706; then one dl_done pulse.
- 3 bytes AA, BB, CC at addr 0x10..0x12, then downl falls -> writes (a=8, ds=11, d=BBAA) and (a=9, ds=01, d=00CC); dl_done follows the second ack.
- Odd-only byte 5A at addr 0x21 -> single write a=0x10, ds=10, d=5A00.
- Ack withheld for 100 cycles while bytes stream in every 2 cycles (FIFO_DEPTH=4) -> dl_wait high once 3 words are queued; overflow stays 0 if the source honours dl_wait. When the source ignores dl_wait, overflow=1 and exactly the excess bytes are missing from the write stream.
- BASE_WORD=23'h7FFFFF, byte pair at addr 0,1 -> a=23'h7FFFFF; next pair at 2,3 -> a=0 (wrap).
- init_n pulsed low during WAIT -> port_req=0, port_we=0, dl_wait=0 immediately; no write after release until new ioctl_wr strobes arrive.

Source files
------------

// File: rtl/sdram_dl_writer.sv
// Turns the byte-wide ioctl download stream into 16-bit SDRAM word writes on a toggle req/ack port.
// Bytes are paired into words, buffered in a small FIFO, and a pulse reports when every write has been acked.
module sdram_dl_writer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [22:0] BASE_WORD  = 23'h0
) (
   input  logic        clk,
   input  logic        init_n,
   input  logic        ioctl_downl,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        dl_wait,
   output logic        dl_done,
   output logic        overflow,
   output logic        port_req,
   input  logic        port_ack,
   output logic        port_we,
   output logic [22:0] port_a,
   output logic [1:0]  port_ds,
   output logic [15:0] port_d
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned EW = 23 + 2 + 16;

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          hold_valid;
   logic [22:0]   hold_a;
   logic [7:0]    hold_d;
   logic          downl_q;
   logic          flush_pend;
   logic          busy;

   logic          byte_in;
   logic          fall;
   logic          same_word;
   logic [22:0]   in_a;
   logic          push;
   logic          push_ok;
   logic          pop;
   logic          full;
   logic          empty;
   logic          done_cond;
   logic [22:0]   push_a;
   logic [1:0]    push_ds;
   logic [15:0]   push_d;
   logic          unused_addr_msb;

   assign unused_addr_msb = ioctl_addr[24];
   assign byte_in   = ioctl_wr & ioctl_downl;
   assign fall      = downl_q & ~ioctl_downl;
   assign in_a      = ioctl_addr[23:1] + BASE_WORD;
   assign same_word = hold_valid && (hold_a == in_a);
   assign full      = (count == CW'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign pop       = (state == IDLE) && !empty;
   assign push_ok   = push && !full;
   assign done_cond = !ioctl_downl && !downl_q && !flush_pend && !hold_valid &&
                      empty && (state == IDLE) && busy;

   // Byte assembler: decide what (if anything) enters the FIFO this cycle.
   always_comb begin
      push    = 1'b0;
      push_a  = hold_a;
      push_ds = 2'b01;
      push_d  = {8'h00, hold_d};
      if (byte_in) begin
         if (!ioctl_addr[0]) begin
            push = hold_valid;
         end else if (same_word) begin
            push    = 1'b1;
            push_ds = 2'b11;
            push_d  = {ioctl_dout, hold_d};
         end else begin
            push    = 1'b1;
            push_a  = in_a;
            push_ds = 2'b10;
            push_d  = {ioctl_dout, 8'h00};
         end
      end else if (flush_pend && hold_valid) begin
         push = 1'b1;
      end
   end

   // Holder, FIFO bookkeeping, throttle and completion tracking.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         downl_q    <= 1'b0;
         flush_pend <= 1'b0;
         hold_valid <= 1'b0;
         hold_a     <= '0;
         hold_d     <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         dl_wait    <= 1'b0;
         busy       <= 1'b0;
         dl_done    <= 1'b0;
      end else begin
         downl_q <= ioctl_downl;
         if (fall) begin
            flush_pend <= 1'b1;
         end else if (!byte_in) begin
            flush_pend <= 1'b0;
         end
         if (byte_in && !ioctl_addr[0]) begin
            hold_valid <= 1'b1;
            hold_a     <= in_a;
            hold_d     <= ioctl_dout;
         end else if (byte_in && same_word) begin
            hold_valid <= 1'b0;
         end else if (!byte_in && flush_pend) begin
            hold_valid <= 1'b0;
         end
         if (push_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push_ok) - CW'(pop);
         if (push && full) begin
            overflow <= 1'b1;
         end
         dl_wait <= (count >= CW'(FIFO_DEPTH - 1));
         if (ioctl_downl) begin
            busy <= 1'b1;
         end else if (done_cond) begin
            busy <= 1'b0;
         end
         dl_done <= done_cond;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {push_a, push_ds, push_d};
      end
   end

   // Request FSM: one outstanding toggle request at a time, at least one idle cycle between requests.
   always_ff @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         state    <= IDLE;
         port_req <= 1'b0;
         port_we  <= 1'b0;
         port_a   <= '0;
         port_ds  <= '0;
         port_d   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  {port_a, port_ds, port_d} <= mem[rd_ptr];
                  port_we  <= 1'b1;
                  port_req <= ~port_req;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (port_ack == port_req) begin
                  port_we <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_dl_writer.sv
// Scoreboard bench for sdram_dl_writer: expected writes are queued at stimulus time and
// popped by a monitor whenever a DUT request toggle appears.
module tb_sdram_dl_writer;
   typedef struct packed {
      logic [22:0] a;
      logic [1:0]  ds;
      logic [15:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        init_n;
   logic [1:0]  downl;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [1:0]  dl_wait, dl_done, overflow, port_req, port_ack, port_we;
   logic [22:0] port_a  [2];
   logic [1:0]  port_ds [2];
   logic [15:0] port_d  [2];
   logic        hold_ack;
   int          ack_dly;
   int          ack_cnt  [2];
   logic        req_prev [2] = '{1'b0, 1'b0};
   int          done_cnt [2] = '{0, 0};
   int          checks = 0;
   int          failures = 0;
   exp_t        exp_q [$];

   always #5 clk = ~clk;

   // Instance 0 uses BASE_WORD=0, instance 1 exercises address wrap.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      sdram_dl_writer #(
         .FIFO_DEPTH(4),
         .BASE_WORD ((g == 0) ? 23'h0 : 23'h7FFFFF)
      ) u_dut (
         .clk        (clk),
         .init_n     (init_n),
         .ioctl_downl(downl[g]),
         .ioctl_wr   (ioctl_wr),
         .ioctl_addr (ioctl_addr),
         .ioctl_dout (ioctl_dout),
         .dl_wait    (dl_wait[g]),
         .dl_done    (dl_done[g]),
         .overflow   (overflow[g]),
         .port_req   (port_req[g]),
         .port_ack   (port_ack[g]),
         .port_we    (port_we[g]),
         .port_a     (port_a[g]),
         .port_ds    (port_ds[g]),
         .port_d     (port_d[g])
      );
   end

   // Controller model: echoes the request toggle ack_dly cycles later unless held off.
   always @(posedge clk or negedge init_n) begin
      if (!init_n) begin
         port_ack   <= '0;
         ack_cnt[0] <= 0;
         ack_cnt[1] <= 0;
      end else begin
         for (int g = 0; g < 2; g++) begin
            if (port_req[g] != port_ack[g] && !hold_ack) begin
               if (ack_cnt[g] >= ack_dly - 1) begin
                  port_ack[g] <= port_req[g];
                  ack_cnt[g]  <= 0;
               end else begin
                  ack_cnt[g] <= ack_cnt[g] + 1;
               end
            end else begin
               ack_cnt[g] <= 0;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask

   task automatic check_write(input int g, input exp_t got, input logic we);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL write%0d unexpected: got a=%0h ds=%0h d=%0h", g, got.a, got.ds, got.d);
      end else begin
         e = exp_q.pop_front();
         if (got !== e || we !== 1'b1) begin
            failures++;
            $display("FAIL write%0d: got a=%0h ds=%0h d=%0h we=%0b, expected a=%0h ds=%0h d=%0h we=1",
                     g, got.a, got.ds, got.d, we, e.a, e.ds, e.d);
         end
      end
   endtask

   // Monitor: a change of port_req marks a newly issued write.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         if (dl_done[g]) done_cnt[g]++;
         if (!init_n) begin
            req_prev[g] = 1'b0;
         end else if (port_req[g] != req_prev[g]) begin
            req_prev[g] = port_req[g];
            check_write(g, {port_a[g], port_ds[g], port_d[g]}, port_we[g]);
         end
      end
   end

   task automatic expect_wr(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
      exp_t e;
      e.a  = a;
      e.ds = ds;
      e.d  = d;
      exp_q.push_back(e);
   endtask

   task automatic send_byte(input logic [24:0] adr, input logic [7:0] dat, input bit honor);
      int guard = 0;
      while (honor && dl_wait[0] && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 400) begin
         checks++;
         failures++;
         $display("FAIL send_byte: dl_wait stuck at %0b, expected release", dl_wait[0]);
      end
      ioctl_addr = adr;
      ioctl_dout = dat;
      ioctl_wr   = 1'b1;
      @(negedge clk);
      ioctl_wr   = 1'b0;
      @(negedge clk);
   endtask

   task automatic drain(input string nm);
      int n = 0;
      while ((exp_q.size() != 0 || port_req != port_ack) && n < 500) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 500) begin
         failures++;
         $display("FAIL %s drain: %0d writes still missing, expected 0", nm, exp_q.size());
      end
   endtask

   task automatic end_dl(input int g, input string nm);
      int start;
      start    = done_cnt[g];
      downl[g] = 1'b0;
      drain(nm);
      repeat (20) @(negedge clk);
      chk({nm, " done pulses"}, 64'(done_cnt[g] - start), 64'd1);
   endtask

   initial begin
      int start;
      init_n     = 1'b0;
      downl      = 2'b00;
      ioctl_wr   = 1'b0;
      ioctl_addr = '0;
      ioctl_dout = '0;
      hold_ack   = 1'b0;
      ack_dly    = 3;
      #27;
      chk("reset port_req", 64'(port_req[0]), 64'd0);
      chk("reset port_we", 64'(port_we[0]), 64'd0);
      chk("reset port_a", 64'(port_a[0]), 64'd0);
      chk("reset port_ds", 64'(port_ds[0]), 64'd0);
      chk("reset port_d", 64'(port_d[0]), 64'd0);
      chk("reset dl_wait", 64'(dl_wait[0]), 64'd0);
      chk("reset dl_done", 64'(dl_done[0]), 64'd0);
      chk("reset overflow", 64'(overflow[0]), 64'd0);
      @(negedge clk);
      init_n = 1'b1;
      repeat (3) @(negedge clk);

      // Sequential bytes 00..07 -> four full words.
      downl[0] = 1'b1;
      expect_wr(23'h0, 2'b11, 16'h0100);
      expect_wr(23'h1, 2'b11, 16'h0302);
      expect_wr(23'h2, 2'b11, 16'h0504);
      expect_wr(23'h3, 2'b11, 16'h0706);
      for (int i = 0; i < 8; i++) send_byte(25'(i), 8'(i), 1'b0);
      end_dl(0, "seq");

      // Trailing even byte flushed when the download ends.
      downl[0] = 1'b1;
      expect_wr(23'h8, 2'b11, 16'hBBAA);
      expect_wr(23'h9, 2'b01, 16'h00CC);
      send_byte(25'h10, 8'hAA, 1'b0);
      send_byte(25'h11, 8'hBB, 1'b0);
      send_byte(25'h12, 8'hCC, 1'b0);
      end_dl(0, "flush");

      // Lone odd byte.
      downl[0] = 1'b1;
      expect_wr(23'h10, 2'b10, 16'h5A00);
      send_byte(25'h21, 8'h5A, 1'b0);
      end_dl(0, "odd");

      // Even after even, odd to a different word while holding, then flush.
      downl[0] = 1'b1;
      expect_wr(23'h80, 2'b01, 16'h0050);
      expect_wr(23'h82, 2'b11, 16'h5251);
      expect_wr(23'h89, 2'b10, 16'h6100);
      expect_wr(23'h88, 2'b01, 16'h0060);
      send_byte(25'h100, 8'h50, 1'b0);
      send_byte(25'h104, 8'h51, 1'b0);
      send_byte(25'h105, 8'h52, 1'b0);
      send_byte(25'h110, 8'h60, 1'b0);
      send_byte(25'h113, 8'h61, 1'b0);
      end_dl(0, "holder");

      // Download with no bytes still reports completion.
      downl[0] = 1'b1;
      repeat (3) @(negedge clk);
      end_dl(0, "empty");

      // Ack withheld, source honours dl_wait.
      downl[0] = 1'b1;
      hold_ack = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_wr(23'h20 + 23'(i), 2'b11, {8'hA1 + 8'(2 * i), 8'hA0 + 8'(2 * i)});
         send_byte(25'h40 + 25'(2 * i), 8'hA0 + 8'(2 * i), 1'b1);
         send_byte(25'h41 + 25'(2 * i), 8'hA1 + 8'(2 * i), 1'b1);
         if (i == 2) chk("throttle two queued dl_wait", 64'(dl_wait[0]), 64'd0);
      end
      repeat (100) @(negedge clk);
      chk("throttle three queued dl_wait", 64'(dl_wait[0]), 64'd1);
      chk("throttle overflow", 64'(overflow[0]), 64'd0);
      hold_ack = 1'b0;
      end_dl(0, "throttle");
      chk("throttle dl_wait after drain", 64'(dl_wait[0]), 64'd0);

      // Ack withheld, source ignores dl_wait: words 5 and 6 are dropped.
      downl[0] = 1'b1;
      hold_ack = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (i < 5) expect_wr(23'h30 + 23'(i), 2'b11, {8'hC1 + 8'(2 * i), 8'hC0 + 8'(2 * i)});
         send_byte(25'h60 + 25'(2 * i), 8'hC0 + 8'(2 * i), 1'b0);
         send_byte(25'h61 + 25'(2 * i), 8'hC1 + 8'(2 * i), 1'b0);
      end
      repeat (5) @(negedge clk);
      chk("overflow set", 64'(overflow[0]), 64'd1);
      hold_ack = 1'b0;
      end_dl(0, "overflow");
      chk("overflow sticky", 64'(overflow[0]), 64'd1);

      // Reset while a request is outstanding.
      downl[0] = 1'b1;
      hold_ack = 1'b1;
      expect_wr(23'h40, 2'b11, 16'h2211);
      send_byte(25'h80, 8'h11, 1'b0);
      send_byte(25'h81, 8'h22, 1'b0);
      repeat (6) @(negedge clk);
      chk("pre-reset port_we", 64'(port_we[0]), 64'd1);
      start = done_cnt[0];
      #2;
      init_n   = 1'b0;
      downl[0] = 1'b0;
      #1;
      chk("mid reset port_req", 64'(port_req[0]), 64'd0);
      chk("mid reset port_we", 64'(port_we[0]), 64'd0);
      chk("mid reset dl_wait", 64'(dl_wait[0]), 64'd0);
      chk("mid reset overflow", 64'(overflow[0]), 64'd0);
      repeat (2) @(negedge clk);
      #2;
      init_n   = 1'b1;
      hold_ack = 1'b0;
      repeat (30) @(negedge clk);
      chk("post reset port_req", 64'(port_req[0]), 64'd0);
      chk("post reset done pulses", 64'(done_cnt[0] - start), 64'd0);

      // BASE_WORD = 7FFFFF wraps to 0 on the second word.
      downl[1] = 1'b1;
      expect_wr(23'h7FFFFF, 2'b11, 16'h2211);
      expect_wr(23'h0, 2'b11, 16'h4433);
      send_byte(25'h0, 8'h11, 1'b0);
      send_byte(25'h1, 8'h22, 1'b0);
      send_byte(25'h2, 8'h33, 1'b0);
      send_byte(25'h3, 8'h44, 1'b0);
      end_dl(1, "wrap");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
